// File: rtl/bioz_siggen_clkgen.sv
// bioz_siggen_clkgen: divides clk into a glitch-free quadrature I/Q excitation clock pair with Fsel-selected frequency
module bioz_siggen_clkgen #(
  parameter int BASE_DIV = 256,
  parameter int FSEL_MAX = 10,
  parameter int CNT_W    = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] Fsel,
  output logic       clk_i,
  output logic       clk_q,
  output logic       period_strobe,
  output logic       running,
  output logic [3:0] fsel_active,
  output logic       fsel_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic en_m, en_s, strobe_q, strobe_nx, err_nx, load, tc;
  logic [1:0] phase, phase_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, term;
  logic [3:0] fsel_cl, fsel_nx;
  assign fsel_cl = (Fsel > 4'(FSEL_MAX)) ? 4'(FSEL_MAX) : Fsel;
  assign term = (CNT_W'(BASE_DIV) << fsel_active) - CNT_W'(1);
  assign tc = cnt == term;
  // the entry cycle counts as the first cycle of the period, so strobe/running come straight from en_s
  assign running = (state == RUN) | en_s;
  assign period_strobe = strobe_q | ((state == IDLE) & en_s);
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    phase_nx = phase;
    strobe_nx = 1'b0;
    load = 1'b0;
    if (state == IDLE) begin
      if (en_s) begin
        state_nx = RUN;
        cnt_nx = CNT_W'(1);
        load = 1'b1;
      end
    end else if (!en_s) begin
      state_nx = IDLE;
      cnt_nx = '0;
      phase_nx = 2'd0;
    end else if (tc) begin
      cnt_nx = '0;
      phase_nx = phase + 2'd1;
      load = phase == 2'd3;
      strobe_nx = phase == 2'd3;
    end else begin
      cnt_nx = cnt + CNT_W'(1);
    end
    fsel_nx = load ? fsel_cl : fsel_active;
    err_nx = fsel_err | (load & (Fsel > 4'(FSEL_MAX)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_m <= 1'b0;
      en_s <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      phase <= 2'd0;
      clk_i <= 1'b0;
      clk_q <= 1'b0;
      strobe_q <= 1'b0;
      fsel_active <= 4'd0;
      fsel_err <= 1'b0;
    end else begin
      en_m <= enable;
      en_s <= en_m;
      state <= state_nx;
      cnt <= cnt_nx;
      phase <= phase_nx;
      clk_i <= phase_nx[1];
      clk_q <= phase_nx[1] ^ phase_nx[0];
      strobe_q <= strobe_nx;
      fsel_active <= fsel_nx;
      fsel_err <= err_nx;
    end
  end
endmodule

// File: tb/tb_bioz_siggen_clkgen.sv
// tb_bioz_siggen_clkgen: random and directed checks of the I/Q clock generator against a period-position model
module tb_bioz_siggen_clkgen;
  localparam int B = 4, FM = 10, CW = 14;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [3:0] Fsel = 4'd0;
  logic clk_i, clk_q, period_strobe, running, fsel_err;
  logic [3:0] fsel_active;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  bioz_siggen_clkgen #(.BASE_DIV(B), .FSEL_MAX(FM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .Fsel(Fsel), .clk_i(clk_i), .clk_q(clk_q),
    .period_strobe(period_strobe), .running(running), .fsel_active(fsel_active), .fsel_err(fsel_err));
  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic int clampf(input int f);
    return f > FM ? FM : f;
  endfunction
  // model: position t within the current output period plus the code that sets its length
  logic m_en1, m_en2, m_run, m_err;
  int m_t, m_f;
  always @(posedge clk or posedge rst) begin
    int t, f;
    logic run, err;
    if (rst) begin
      m_en1 <= 1'b0; m_en2 <= 1'b0; m_run <= 1'b0; m_err <= 1'b0; m_t <= 0; m_f <= 0;
    end else begin
      t = m_t; f = m_f; run = m_run; err = m_err;
      if (m_run) begin
        if (!m_en2) begin
          run = 1'b0; t = 0;
        end else if (m_t == 4 * (B << m_f) - 1) begin
          t = 0; f = clampf(int'(Fsel)); err = err | (Fsel > FM);
        end else t = m_t + 1;
      end else if (m_en2) begin
        run = 1'b1; t = 1; f = clampf(int'(Fsel)); err = err | (Fsel > FM);
      end
      m_t <= t; m_f <= f; m_run <= run; m_err <= err;
      m_en2 <= m_en1; m_en1 <= enable;
    end
  end
  always @(negedge clk) begin
    int q;
    q = m_run ? m_t / (B << m_f) : 0;
    chk("clk_i", int'(clk_i), int'(q >= 2));
    chk("clk_q", int'(clk_q), int'(q == 1 || q == 2));
    chk("running", int'(running), int'(m_run || m_en2));
    chk("period_strobe", int'(period_strobe), int'((!m_run && m_en2) || (m_run && m_t == 0)));
    chk("fsel_active", int'(fsel_active), m_f);
    chk("fsel_err", int'(fsel_err), int'(m_err));
  end
  task automatic wait_strobe(input int lim, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!period_strobe && n < lim);
    chk("strobe_wait", int'(period_strobe), 1);
  endtask
  task automatic wait_run(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!running && n < 10);
  endtask
  task automatic measure(input int lim, output int qr, output int ir, output int per, output int hi);
    qr = -1; ir = -1; per = -1; hi = 0;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (qr < 0 && clk_q) qr = k;
      if (ir < 0 && clk_i) ir = k;
      if (period_strobe) begin per = k; break; end
      hi += int'(clk_i);
    end
  endtask
  initial begin
    int n, qr, ir, per, hi, r, s;
    repeat (3) @(negedge clk);
    chk("rst_running", int'(running), 0);
    chk("rst_fsel_active", int'(fsel_active), 0);
    chk("rst_strobe", int'(period_strobe), 0);
    rst = 1'b0;
    @(negedge clk);
    #2 Fsel = 4'd0; enable = 1'b1;
    wait_run(n);
    chk("run_latency", n, 2);
    chk("entry_strobe", int'(period_strobe), 1);
    measure(100, qr, ir, per, hi);
    chk("f0_q_rise", qr, 4);
    chk("f0_i_rise", ir, 8);
    chk("f0_period", per, 16);
    chk("f0_high", hi, 8);
    Fsel = 4'd3;
    wait_strobe(100, n);
    chk("f3_active", int'(fsel_active), 3);
    measure(1000, qr, ir, per, hi);
    chk("f3_period", per, 128);
    chk("f3_high", hi, 64);
    measure(1000, qr, ir, per, hi);
    chk("f3_period2", per, 128);
    Fsel = 4'd0;
    wait_strobe(200, n);
    chk("f0_reload", int'(fsel_active), 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!clk_q && n < 20);
    chk("phase1_at", n, 4);
    Fsel = 4'd5;
    wait_strobe(100, n);
    chk("f0_completes", n, 12);
    chk("f5_active", int'(fsel_active), 5);
    measure(2000, qr, ir, per, hi);
    chk("f5_period", per, 512);
    Fsel = 4'd1;
    n = 0;
    do begin @(negedge clk); n++; end while (!clk_i && n < 600);
    chk("clk_i_high", int'(clk_i), 1);
    #2 enable = 1'b0;
    s = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      s += int'(period_strobe);
      if (k == 2) chk("still_running", int'(running), 1);
    end
    chk("stop_running", int'(running), 0);
    chk("stop_clk_i", int'(clk_i), 0);
    chk("stop_strobes", s, 0);
    #402 enable = 1'b1;
    wait_run(n);
    chk("restart_latency", n, 2);
    chk("restart_strobe", int'(period_strobe), 1);
    measure(200, qr, ir, per, hi);
    chk("f1_q_rise", qr, 8);
    chk("f1_period", per, 32);
    repeat (250) begin
      @(negedge clk);
      #($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      if (r < 3) Fsel = 4'($urandom_range(0, 6));
      else if (r < 5) enable = ~enable;
      repeat ($urandom_range(1, 80)) @(negedge clk);
    end
    enable = 1'b1;
    Fsel = 4'd13;
    repeat (4) @(negedge clk);
    wait_strobe(20000, n);
    chk("f13_active", int'(fsel_active), 10);
    chk("f13_err", int'(fsel_err), 1);
    Fsel = 4'd2;
    measure(20000, qr, ir, per, hi);
    chk("f13_period", per, 16384);
    chk("f2_active", int'(fsel_active), 2);
    chk("err_sticky", int'(fsel_err), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!clk_i && n < 100);
    chk("pre_rst_clk_i", int'(clk_i), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_clk_i", int'(clk_i), 0);
    chk("arst_clk_q", int'(clk_q), 0);
    chk("arst_running", int'(running), 0);
    chk("arst_strobe", int'(period_strobe), 0);
    chk("arst_fsel_active", int'(fsel_active), 0);
    chk("arst_err", int'(fsel_err), 0);
    Fsel = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    wait_run(n);
    chk("post_rst_latency", n, 2);
    chk("post_rst_strobe", int'(period_strobe), 1);
    measure(100, qr, ir, per, hi);
    chk("post_rst_period", per, 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
